weight_update_vec: RTL and testbench

- Feedback-path counterpart to the dot-product adder tree in the simplified CCSDS-123.0-B-2 predictor.
- The adder tree reduces six weight×local-difference products into a predicted value. This block runs the other direction: it takes the prediction-error sign and the same six local differences, and updates the six-entry weight vector that feeds the multipliers.
- Weights are held internally, initialised per CCSDS rules, updated via a 3-state FSM with a ready/enable handshake, and saturated to the weight range.

---
 rtl/weight_update_vec.sv | 143 ++++++++++++++
 tb/tb_weight_update_vec.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_vec.sv
// weight_update_vec: feedback-path weight updater for the simplified CCSDS-123 predictor.
// Holds the six-entry signed weight vector that feeds the dot-product multipliers and
// updates it from the prediction-error sign and the six local differences.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous reset, active-low (weights load the initial vector)
//   init       synchronous re-initialisation of the weights (highest priority)
//   upd_en     update request, accepted only while upd_ready=1
//   upd_ready  idle and able to accept an update
//   err_neg    1 = prediction error negative
//   rho        right-shift exponent applied to the signed local difference
//   ld         packed signed local differences, component k at [k*D_WIDTH +: D_WIDTH]
//   w          packed signed weights, same ordering, straight from the weight registers
//   w_valid    one-cycle pulse after the weights change (update applied or init)
module weight_update_vec #(
    parameter int unsigned OMEGA     = 16,
    parameter int unsigned WT_WIDTH  = OMEGA + 3,
    parameter int unsigned D_WIDTH   = 15,
    parameter int unsigned RHO_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init,
    input  logic                      upd_en,
    output logic                      upd_ready,
    input  logic                      err_neg,
    input  logic [RHO_WIDTH-1:0]      rho,
    input  logic [6*D_WIDTH-1:0]      ld,
    output logic [6*WT_WIDTH-1:0]     w,
    output logic                      w_valid
);

    // t needs one extra bit so negating the most negative difference cannot overflow;
    // the delta path carries one more for the +1 rounding term.
    localparam int unsigned TW = D_WIDTH + 1;
    localparam int unsigned DW = D_WIDTH + 2;
    localparam int unsigned SW = WT_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StApply} state_e;

    state_e                    state;
    logic                      err_neg_q;
    logic [RHO_WIDTH-1:0]      rho_q;
    logic [6*D_WIDTH-1:0]      ld_q;
    logic signed [DW-1:0]      delta_q [6];
    logic signed [WT_WIDTH-1:0] w_q    [6];

    logic signed [TW-1:0]      t_val   [6];
    logic signed [TW-1:0]      s_val   [6];
    logic signed [DW-1:0]      s_inc   [6];
    logic signed [DW-1:0]      delta_d [6];
    logic signed [SW-1:0]      sum     [6];
    logic signed [WT_WIDTH-1:0] w_sat  [6];

    // Initial vector: W0 = 7*2^(OMEGA-3), each next entry is the previous divided by 8.
    function automatic logic signed [WT_WIDTH-1:0] init_weight(input int unsigned k);
        logic [WT_WIDTH-1:0] w0;
        w0 = WT_WIDTH'(7) << (OMEGA - 3);
        return $signed(w0 >> (3 * k));
    endfunction

    assign upd_ready = (state == StIdle) & ~init;

    for (genvar g = 0; g < 6; g++) begin : g_wout
        assign w[g*WT_WIDTH +: WT_WIDTH] = w_q[g];
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            t_val[k] = $signed({ld_q[k*D_WIDTH + D_WIDTH - 1], ld_q[k*D_WIDTH +: D_WIDTH]});
            if (err_neg_q) begin
                t_val[k] = -t_val[k];
            end
            s_val[k]   = t_val[k] >>> rho_q;
            // Round half up: (s + 1) >>> 1.
            s_inc[k]   = $signed({s_val[k][TW-1], s_val[k]}) +
                         $signed({{(DW-1){1'b0}}, 1'b1});
            delta_d[k] = s_inc[k] >>> 1;

            sum[k] = $signed({w_q[k][WT_WIDTH-1], w_q[k]}) +
                     $signed({{(SW-DW){delta_q[k][DW-1]}}, delta_q[k]});
            // Top two bits disagree only when the sum left the weight range.
            if (sum[k][SW-1] != sum[k][SW-2]) begin
                w_sat[k] = sum[k][SW-1] ? $signed({1'b1, {(WT_WIDTH-1){1'b0}}})
                                        : $signed({1'b0, {(WT_WIDTH-1){1'b1}}});
            end else begin
                w_sat[k] = sum[k][WT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            w_valid   <= 1'b0;
            err_neg_q <= 1'b0;
            rho_q     <= '0;
            ld_q      <= '0;
            for (int k = 0; k < 6; k++) begin
                delta_q[k] <= '0;
                w_q[k]     <= init_weight(k);
            end
        end else begin
            w_valid <= 1'b0;
            if (init) begin
                // Any captured request or pending delta is dropped.
                state   <= StIdle;
                w_valid <= 1'b1;
                for (int k = 0; k < 6; k++) begin
                    delta_q[k] <= '0;
                    w_q[k]     <= init_weight(k);
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        if (upd_en) begin
                            err_neg_q <= err_neg;
                            rho_q     <= rho;
                            ld_q      <= ld;
                            state     <= StCalc;
                        end
                    end
                    StCalc: begin
                        for (int k = 0; k < 6; k++) begin
                            delta_q[k] <= delta_d[k];
                        end
                        state <= StApply;
                    end
                    StApply: begin
                        for (int k = 0; k < 6; k++) begin
                            w_q[k] <= w_sat[k];
                        end
                        w_valid <= 1'b1;
                        state   <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_update_vec.sv
module tb_weight_update_vec;

    localparam int D  = 15;
    localparam int WT = 19;

    typedef struct packed {
        logic            en;
        logic [4:0]      rho;
        logic [5:0][31:0] ld;
        logic [5:0][31:0] dl;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init = 1'b0;
    logic              upd_en = 1'b0;
    logic              err_neg = 1'b0;
    logic [4:0]        rho = '0;
    logic [6*D-1:0]    ld = '0;
    logic [6*WT-1:0]   w;
    logic              upd_ready;
    logic              w_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int init_w[6] = '{57344, 7168, 896, 112, 14, 1};
    int exp_w[6];
    vec_t vecs[8];

    weight_update_vec #(
        .OMEGA(16),
        .WT_WIDTH(19),
        .D_WIDTH(15),
        .RHO_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .init(init),
        .upd_en(upd_en),
        .upd_ready(upd_ready),
        .err_neg(err_neg),
        .rho(rho),
        .ld(ld),
        .w(w),
        .w_valid(w_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic int get_w(input int k);
        return int'($signed(w[k*WT +: WT]));
    endfunction

    task automatic check_w(input string name);
        int bad = -1;
        for (int k = 0; k < 6; k++) begin
            if (bad < 0 && get_w(k) != exp_w[k]) bad = k;
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: w[%0d] got %0d required %0d", name, bad, get_w(bad), exp_w[bad]);
        end
    endtask

    function automatic logic [6*D-1:0] pack_ld(input int a0, a1, a2, a3, a4, a5);
        int a[6];
        logic [6*D-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5};
        for (int k = 0; k < 6; k++) r[k*D +: D] = a[k][D-1:0];
        return r;
    endfunction

    function automatic vec_t mk(input logic en, input int r,
                                input int l0, l1, l2, l3, l4, l5,
                                input int d0, d1, d2, d3, d4, d5);
        vec_t v;
        v.en  = en;
        v.rho = r[4:0];
        v.ld[0] = l0; v.ld[1] = l1; v.ld[2] = l2; v.ld[3] = l3; v.ld[4] = l4; v.ld[5] = l5;
        v.dl[0] = d0; v.dl[1] = d1; v.dl[2] = d2; v.dl[3] = d3; v.dl[4] = d4; v.dl[5] = d5;
        return v;
    endfunction

    task automatic do_init();
        init = 1'b1;
        tick();
        check("init_valid", int'(w_valid), 1);
        exp_w = init_w;
        check_w("init_w");
        init = 1'b0;
        #1;
        check("init_ready", int'(upd_ready), 1);
        tick();
        check("init_valid_drop", int'(w_valid), 0);
    endtask

    task automatic do_update(input logic en, input int r, input logic [6*D-1:0] l,
                             input string name);
        int n = 0;
        while (!upd_ready && n < 10) begin
            tick();
            n++;
        end
        check({name, "_wait"}, int'(upd_ready), 1);
        err_neg = en;
        rho     = r[4:0];
        ld      = l;
        upd_en  = 1'b1;
        tick();
        upd_en = 1'b0;
        check({name, "_rdy1"}, int'(upd_ready), 0);
        check({name, "_val1"}, int'(w_valid), 0);
        tick();
        check({name, "_rdy2"}, int'(upd_ready), 0);
        check({name, "_val2"}, int'(w_valid), 0);
        tick();
        check({name, "_val3"}, int'(w_valid), 1);
        check({name, "_rdy3"}, int'(upd_ready), 1);
    endtask

    initial begin
        int nvalid;

        // en, rho, ld0..ld5, hand-computed delta0..delta5
        vecs[0] = mk(0, 0,    100,      0, 0,  0,    0,   0,   50,     0, 0,  0, 0, 0);
        vecs[1] = mk(0, 0,     -3,      0, 0,  0,    0,   0,   -1,     0, 0,  0, 0, 0);
        vecs[2] = mk(1, 1,      3,      0, 0,  0,    0,   0,   -1,     0, 0,  0, 0, 0);
        vecs[3] = mk(0, 31,    -1,      0, 0,  0,    0,   0,    0,     0, 0,  0, 0, 0);
        vecs[4] = mk(0, 2,     40,    -40, 7, -7,    0,   1,    5,    -5, 1, -1, 0, 0);
        vecs[5] = mk(1, 0, -16384,  16383, 0,  0,    0,   0, 8192, -8191, 0,  0, 0, 0);
        vecs[6] = mk(0, 20, 16383, -16384, 0,  0,    0,   0,    0,     0, 0,  0, 0, 0);
        vecs[7] = mk(1, 3,      0,      0, 0,  0, -100, -20,    0,     0, 0,  0, 6, 1);

        // Reset state
        tick();
        check("rst_valid", int'(w_valid), 0);
        rst_n = 1'b1;
        tick();
        exp_w = init_w;
        check_w("rst_w");
        check("rst_valid_after", int'(w_valid), 0);
        check("rst_ready", int'(upd_ready), 1);

        do_init();

        // Table-driven single updates from the initial vector
        for (int i = 0; i < 8; i++) begin
            logic [6*D-1:0] l;
            do_init();
            for (int k = 0; k < 6; k++) l[k*D +: D] = vecs[i].ld[k][D-1:0];
            do_update(vecs[i].en, int'(vecs[i].rho), l, $sformatf("vec%0d", i));
            for (int k = 0; k < 6; k++) exp_w[k] = init_w[k] + int'($signed(vecs[i].dl[k]));
            check_w($sformatf("vec%0d_w", i));
        end

        // Positive saturation: delta = 8192 per update
        do_init();
        for (int n = 1; n <= 26; n++) begin
            do_update(0, 0, pack_ld(16383, 0, 0, 0, 0, 0), $sformatf("satp%0d", n));
            if (n == 24) check("satp_24", get_w(0), 253952);
            if (n == 25) check("satp_25", get_w(0), 262143);
            if (n == 26) check("satp_26", get_w(0), 262143);
        end
        exp_w = init_w;
        exp_w[0] = 262143;
        check_w("satp_w");

        // Negative saturation: delta = -8192 per update, reaches the floor exactly at 39
        do_init();
        for (int n = 1; n <= 40; n++) begin
            do_update(0, 0, pack_ld(-16384, 0, 0, 0, 0, 0), $sformatf("satn%0d", n));
            if (n == 38) check("satn_38", get_w(0), -253952);
            if (n == 39) check("satn_39", get_w(0), -262144);
            if (n == 40) check("satn_40", get_w(0), -262144);
        end

        // upd_en held high: one update per 3 cycles
        do_init();
        err_neg = 1'b0;
        rho     = '0;
        ld      = pack_ld(2, 0, 0, 0, 0, 0);
        upd_en  = 1'b1;
        nvalid  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("hold_rdy%0d", i), int'(upd_ready), (i % 3 == 2) ? 1 : 0);
            check($sformatf("hold_val%0d", i), int'(w_valid), (i % 3 == 2) ? 1 : 0);
            if (w_valid) nvalid++;
        end
        upd_en = 1'b0;
        check("hold_count", nvalid, 4);
        exp_w = init_w;
        exp_w[0] = 57348;
        check_w("hold_w");
        tick();
        check("hold_stop", int'(w_valid), 0);

        // Stray upd_en during CALC/APPLY is ignored
        do_init();
        ld     = pack_ld(100, 0, 0, 0, 0, 0);
        upd_en = 1'b1;
        tick();
        ld = pack_ld(1000, 0, 0, 0, 0, 0);
        tick();
        check("stray_rdy", int'(upd_ready), 0);
        tick();
        upd_en = 1'b0;
        check("stray_val", int'(w_valid), 1);
        check("stray_w0", get_w(0), 57394);
        tick();
        check("stray_val_a", int'(w_valid), 0);
        tick();
        check("stray_val_b", int'(w_valid), 0);
        check("stray_w0_after", get_w(0), 57394);

        // init during CALC discards the pending update
        do_init();
        ld     = pack_ld(100, 0, 0, 0, 0, 0);
        upd_en = 1'b1;
        tick();
        upd_en = 1'b0;
        init   = 1'b1;
        tick();
        check("icalc_val", int'(w_valid), 1);
        exp_w = init_w;
        check_w("icalc_w");
        init = 1'b0;
        #1;
        check("icalc_rdy", int'(upd_ready), 1);
        tick();
        check("icalc_val_a", int'(w_valid), 0);
        tick();
        check("icalc_val_b", int'(w_valid), 0);
        check_w("icalc_w_after");

        // init and upd_en together: init wins
        init   = 1'b1;
        upd_en = 1'b1;
        ld     = pack_ld(100, 0, 0, 0, 0, 0);
        #1;
        check("both_rdy", int'(upd_ready), 0);
        tick();
        check("both_val", int'(w_valid), 1);
        init   = 1'b0;
        upd_en = 1'b0;
        #1;
        check("both_rdy_after", int'(upd_ready), 1);
        tick();
        check("both_val_a", int'(w_valid), 0);
        check("both_idle", int'(upd_ready), 1);
        tick();
        check("both_val_b", int'(w_valid), 0);
        check_w("both_w");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
